// File: rtl/cmos_pack_pkg.sv
// cmos_pack_pkg -- shared definitions for the CMOS pixel packer.
//   state_e         : FSM encoding (SKIP -> WAIT -> ACTIVE -> WAIT)
//   *_DEF           : default sensor geometry and settling-frame count
//   WORDS_PER_FRAME : 32-bit words in a default-size frame (2 pixels/word)
//   WORD_CNT_MAX    : saturation value of the 17-bit word counter
package cmos_pack_pkg;

    typedef enum logic [1:0] {
        ST_SKIP   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    localparam int H_PIXELS_DEF    = 480;
    localparam int V_LINES_DEF     = 272;
    localparam int FRAME_SKIP_DEF  = 10;
    localparam int WORDS_PER_FRAME = H_PIXELS_DEF * V_LINES_DEF / 2;

    localparam logic [16:0] WORD_CNT_MAX = 17'h1FFFF;

endpackage

// File: rtl/cmos_pixel_pack_edge_det.sv
// edge_det -- rise/fall detector on an already-registered signal.
//   clk, rst : clock, asynchronous active-high reset
//   d        : input level (registered upstream)
//   rise     : d is high now and was low last cycle
//   fall     : d is low now and was high last cycle
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev_q, prev_d;

    always_comb prev_d = d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= prev_d;
    end

    assign rise = d & ~prev_q;
    assign fall = ~d & prev_q;

endmodule

// File: rtl/cmos_pixel_pack.sv
// cmos_pixel_pack -- packs an RGB565 CMOS byte stream (high byte first) into
// 32-bit words for a DDR write FIFO. Discards FRAME_SKIP frames after reset.
//   clk, rst           : pixel clock, asynchronous active-high reset
//   cmos_vsync/href    : frame sync (high = blanking), line valid
//   cmos_data[7:0]     : byte stream
//   sys_we             : one-cycle write strobe, sys_data_in valid with it
//   sys_data_in[31:0]  : first pixel [31:16], second pixel [15:0]
//   data_valid_wr      : high while an accepted frame is active
//   frame_switch       : one-cycle pulse at the end of an accepted frame
//   word_cnt[16:0]     : words written in the current/last frame (saturating)
//   frame_err          : only with PACK_FRAME_CHECK_EN; pulses instead of
//                        frame_switch when the frame word count is wrong
module cmos_pixel_pack
    import cmos_pack_pkg::*;
#(
    parameter int H_PIXELS   = H_PIXELS_DEF,
    parameter int V_LINES    = V_LINES_DEF,
    parameter int FRAME_SKIP = FRAME_SKIP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        sys_we,
    output logic [31:0] sys_data_in,
    output logic        data_valid_wr,
    output logic        frame_switch,
`ifdef PACK_FRAME_CHECK_EN
    output logic        frame_err,
`endif
    output logic [16:0] word_cnt
);

    localparam int SKIP_W = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP + 1) : 1;
`ifdef PACK_FRAME_CHECK_EN
    localparam logic [16:0] WORDS_EXP = 17'(H_PIXELS * V_LINES / 2);
`endif

    // Input capture stage: every decision below uses these copies.
    logic        vsync_q, vsync_d, href_q, href_d;
    logic [7:0]  data_q, data_d;

    logic        vsync_rise, vsync_fall, href_rise, href_fall;

    state_e             state_q, state_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic [1:0]         phase_q, phase_d, ph;
    logic [23:0]        word_q, word_d;      // first three bytes of a word
    logic               sys_we_q, sys_we_d;
    logic [31:0]        sys_data_q, sys_data_d;
    logic               frame_switch_q, frame_switch_d;
    logic               frame_err_q, frame_err_d;
    logic [16:0]        word_cnt_q, word_cnt_d;

    edge_det u_vsync_edge (.clk(clk), .rst(rst), .d(vsync_q), .rise(vsync_rise), .fall(vsync_fall));
    edge_det u_href_edge  (.clk(clk), .rst(rst), .d(href_q),  .rise(href_rise),  .fall(href_fall));

    always_comb begin
        vsync_d = cmos_vsync;
        href_d  = cmos_href;
        data_d  = cmos_data;
    end

    always_comb begin
        state_d        = state_q;
        skip_d         = skip_q;
        phase_d        = phase_q;
        word_d         = word_q;
        sys_we_d       = 1'b0;
        sys_data_d     = sys_data_q;
        frame_switch_d = 1'b0;
        frame_err_d    = 1'b0;
        word_cnt_d     = word_cnt_q;
        // A new line always starts pairing at byte 0, whatever was left over.
        ph             = href_rise ? 2'd0 : phase_q;

        case (state_q)
            ST_SKIP: begin
                if (FRAME_SKIP == 0) begin
                    state_d = ST_WAIT;
                end else if (vsync_rise) begin
                    if (int'(skip_q) == FRAME_SKIP - 1) state_d = ST_WAIT;
                    else                                skip_d  = skip_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (vsync_fall) begin
                    state_d    = ST_ACTIVE;
                    word_cnt_d = '0;
                    phase_d    = '0;
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise) begin
                    // Frame ends; a byte arriving this cycle is dropped with
                    // any partial word.
                    state_d = ST_WAIT;
                    phase_d = '0;
`ifdef PACK_FRAME_CHECK_EN
                    if (word_cnt_q == WORDS_EXP) frame_switch_d = 1'b1;
                    else                         frame_err_d    = 1'b1;
`else
                    frame_switch_d = 1'b1;
`endif
                end else if (href_q) begin
                    word_d = {word_q[15:0], data_q};
                    if (ph == 2'd3) begin
                        sys_we_d   = 1'b1;
                        sys_data_d = {word_q, data_q};
                        phase_d    = '0;
                        if (word_cnt_q != WORD_CNT_MAX) word_cnt_d = word_cnt_q + 1'b1;
                    end else begin
                        phase_d = ph + 2'd1;
                    end
                end else if (href_fall) begin
                    phase_d = '0;                // partial word discarded
                end
            end
            default: state_d = ST_SKIP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q        <= 1'b0;
            href_q         <= 1'b0;
            data_q         <= '0;
            state_q        <= ST_SKIP;
            skip_q         <= '0;
            phase_q        <= '0;
            word_q         <= '0;
            sys_we_q       <= 1'b0;
            sys_data_q     <= '0;
            frame_switch_q <= 1'b0;
            frame_err_q    <= 1'b0;
            word_cnt_q     <= '0;
        end else begin
            vsync_q        <= vsync_d;
            href_q         <= href_d;
            data_q         <= data_d;
            state_q        <= state_d;
            skip_q         <= skip_d;
            phase_q        <= phase_d;
            word_q         <= word_d;
            sys_we_q       <= sys_we_d;
            sys_data_q     <= sys_data_d;
            frame_switch_q <= frame_switch_d;
            frame_err_q    <= frame_err_d;
            word_cnt_q     <= word_cnt_d;
        end
    end

    assign sys_we        = sys_we_q;
    assign sys_data_in   = sys_data_q;
    assign data_valid_wr = (state_q == ST_ACTIVE);
    assign frame_switch  = frame_switch_q;
    assign word_cnt      = word_cnt_q;
`ifdef PACK_FRAME_CHECK_EN
    assign frame_err     = frame_err_q;
`else
    logic unused_err;
    assign unused_err    = frame_err_q;
`endif

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Directed bench for cmos_pixel_pack with a small geometry (8x4, skip 2).
module tb_cmos_pixel_pack;

    localparam int H = 8, V = 4, SKIP = 2;
    localparam int WPF = H * V / 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cmos_vsync = 1'b0, cmos_href = 1'b0;
    logic [7:0]  cmos_data = 8'h00;
    logic        sys_we, data_valid_wr, frame_switch;
    logic [31:0] sys_data_in;
    logic [16:0] word_cnt;
`ifdef PACK_FRAME_CHECK_EN
    logic        frame_err;
    int          fe_cnt = 0;
`endif

    cmos_pixel_pack #(.H_PIXELS(H), .V_LINES(V), .FRAME_SKIP(SKIP)) dut (
        .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
        .cmos_data(cmos_data), .sys_we(sys_we), .sys_data_in(sys_data_in),
        .data_valid_wr(data_valid_wr), .frame_switch(frame_switch),
`ifdef PACK_FRAME_CHECK_EN
        .frame_err(frame_err),
`endif
        .word_cnt(word_cnt));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          we_cnt = 0, fs_cnt = 0;
    logic [31:0] we_data[$];
    int          we_cyc[$];
    always @(negedge clk) begin
        if (sys_we) begin
            we_cnt <= we_cnt + 1;
            we_data.push_back(sys_data_in);
            we_cyc.push_back(cyc);
        end
        if (frame_switch) fs_cnt <= fs_cnt + 1;
`ifdef PACK_FRAME_CHECK_EN
        if (frame_err) fe_cnt <= fe_cnt + 1;
`endif
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick(); cmos_href = 1'b1; cmos_data = b;
    endtask

    task automatic end_line();
        tick(); cmos_href = 1'b0; cmos_data = 8'h00;
        repeat (2) tick();
    endtask

    task automatic send_lines(input int first, input int nlines, input logic [7:0] base);
        for (int l = first; l < nlines; l++) begin
            for (int i = 0; i < 2 * H; i++) send_byte(8'(base + l * 16 + i));
            end_line();
        end
    endtask

    task automatic vsync_pulse();
        tick(); cmos_href = 1'b0; cmos_vsync = 1'b1;
        repeat (4) tick();
        cmos_vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},   {31'd0, sys_we},        32'd0);
        chk({tag, "_data"}, sys_data_in,            32'd0);
        chk({tag, "_dv"},   {31'd0, data_valid_wr}, 32'd0);
        chk({tag, "_fs"},   {31'd0, frame_switch},  32'd0);
        chk({tag, "_wc"},   {15'd0, word_cnt},      32'd0);
    endtask

    int c78;

    initial begin
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Two settling frames: nothing written, nothing reported.
        send_lines(0, V, 8'h00); vsync_pulse();
        send_lines(0, V, 8'h00); vsync_pulse();
        chk("skip_no_we", we_cnt, 0);
        chk("skip_no_fs", fs_cnt, 0);
        chk("dv_active",  {31'd0, data_valid_wr}, 32'd1);
        chk("wc_clear",   {15'd0, word_cnt}, 32'd0);

        // Frame 3: first accepted frame.
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        c78 = cyc;
        for (int i = 0; i < 2 * H - 4; i++) send_byte(8'(8'h80 + i));
        end_line();
        send_lines(1, V, 8'h40);
        chk("w0_data",    we_data[0], 32'h12345678);
        chk("w0_latency", we_cyc[0] - c78, 2);
        chk("w1_data",    we_data[1], 32'h80818283);
        tick(); cmos_vsync = 1'b1;
        repeat (3) tick();
        chk("f3_we_cnt", we_cnt, WPF);
        chk("f3_wc",     {15'd0, word_cnt}, WPF);
        chk("f3_fs",     fs_cnt, 1);
        chk("f3_dv_low", {31'd0, data_valid_wr}, 32'd0);
        // Bytes during blanking are ignored.
        for (int i = 0; i < 6; i++) send_byte(8'hEE);
        tick(); cmos_href = 1'b0;
        repeat (2) tick();
        chk("blank_no_we", we_cnt, WPF);
        cmos_vsync = 1'b0;
        repeat (3) tick();
        chk("f4_wc_clear", {15'd0, word_cnt}, 32'd0);

        // Frame 4: 5-byte line, then a full line, then vsync cuts a line.
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i));
        end_line();
        chk("l5_we_cnt", we_cnt, WPF + 1);
        chk("l5_data",   we_data[WPF], 32'hA0A1A2A3);
        for (int i = 0; i < 8; i++) send_byte(8'(8'hB0 + i));
        end_line();
        chk("l8_we_cnt", we_cnt, WPF + 3);
        chk("l8_w0",     we_data[WPF + 1], 32'hB0B1B2B3);
        chk("l8_w1",     we_data[WPF + 2], 32'hB4B5B6B7);
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2);
        tick(); cmos_data = 8'hC3; cmos_vsync = 1'b1;
        repeat (3) tick();
        cmos_href = 1'b0;
        repeat (2) tick();
        chk("cut_we_cnt", we_cnt, WPF + 3);
        chk("cut_wc",     {15'd0, word_cnt}, 32'd3);
        chk("cut_dv",     {31'd0, data_valid_wr}, 32'd0);
`ifdef PACK_FRAME_CHECK_EN
        chk("cut_fs", fs_cnt, 1);
        chk("cut_fe", fe_cnt, 1);
`else
        chk("cut_fs", fs_cnt, 2);
`endif
        cmos_vsync = 1'b0;
        repeat (3) tick();

        // Frame 5: reset in the middle of a line.
        for (int i = 0; i < 6; i++) send_byte(8'(8'hD0 + i));
        tick();
        chk("pre_rst_data", sys_data_in, 32'hD0D1D2D3);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        tick(); rst = 1'b0; cmos_href = 1'b0;
        tick();

        // Settling frames are skipped again after reset.
        send_lines(0, V, 8'h00); vsync_pulse();
        send_lines(0, V, 8'h00);
        chk("reskip_no_we", we_cnt, WPF + 4);
        vsync_pulse();
        send_lines(0, V, 8'h00);
        vsync_pulse();
        chk("reskip_we_cnt", we_cnt, 2 * WPF + 4);
        chk("reskip_data",   we_data[2 * WPF + 3], 32'h3C3D3E3F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
